clk_enable_gen: RTL and testbench

CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

---
 rtl/clk_enable_gen.sv | 80 ++++++++
 tb/tb_clk_enable_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator: each channel's phase accumulator
// emits a one-cycle ce pulse on carry-out, after a post-reset lock interval.
module clk_enable_gen #(
  parameter int NUM_CHANNELS = 4,
  parameter int ACC_WIDTH    = 32,
  parameter logic [NUM_CHANNELS*ACC_WIDTH-1:0] RESET_INC = '0,
  parameter int LOCK_CYCLES  = 16,
  localparam int SEL_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sync,
  input  logic                    wr_en,
  input  logic [SEL_WIDTH-1:0]    wr_sel,
  input  logic [ACC_WIDTH-1:0]    wr_data,
  output logic [NUM_CHANNELS-1:0] ce,
  output logic                    locked
);

  localparam logic [15:0] LOCK_TARGET = 16'(LOCK_CYCLES);

  logic [NUM_CHANNELS-1:0][ACC_WIDTH-1:0] inc;
  logic [NUM_CHANNELS-1:0][ACC_WIDTH-1:0] acc;
  logic [NUM_CHANNELS-1:0][ACC_WIDTH-1:0] inc_next;
  logic [NUM_CHANNELS-1:0][ACC_WIDTH-1:0] acc_next;
  logic [NUM_CHANNELS-1:0][ACC_WIDTH:0]   sum;
  logic [NUM_CHANNELS-1:0]                ce_next;
  logic [15:0]                            lock_cnt;
  logic                                   wr_valid;

  // Sum is one bit wider so the top bit is the carry that becomes the ce pulse.
  for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_sum
    assign sum[n] = {1'b0, acc[n]} + {1'b0, inc[n]};
  end

  assign wr_valid = wr_en && (int'(wr_sel) < NUM_CHANNELS);

  // Writes and sync are applied after accumulation so they override a coincident carry.
  always_comb begin
    acc_next = acc;
    inc_next = inc;
    ce_next  = '0;
    if (locked) begin
      for (int n = 0; n < NUM_CHANNELS; n++) begin
        acc_next[n] = sum[n][ACC_WIDTH-1:0];
        ce_next[n]  = sum[n][ACC_WIDTH];
      end
    end
    if (sync) begin
      acc_next = '0;
      ce_next  = '0;
    end
    if (wr_valid) begin
      inc_next[wr_sel] = wr_data;
      acc_next[wr_sel] = '0;
      ce_next[wr_sel]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ce       <= '0;
      locked   <= 1'b0;
      lock_cnt <= '0;
      acc      <= '0;
      inc      <= RESET_INC;
    end else begin
      ce  <= ce_next;
      acc <= acc_next;
      inc <= inc_next;
      if (!locked) begin
        lock_cnt <= lock_cnt + 16'd1;
        if (lock_cnt + 16'd1 == LOCK_TARGET) begin
          locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen: a cycle model predicts ce, locked and the
// accumulators for every edge; directed scenarios add pulse-timing checks.
module tb_clk_enable_gen;

  localparam int NC = 3;
  localparam int AW = 8;
  localparam int LC = 4;
  localparam logic [NC*AW-1:0] RST_INC = {8'h20, 8'h00, 8'h00};

  typedef struct packed {
    logic [NC-1:0]    ce;
    logic             locked;
    logic [NC*AW-1:0] acc;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          sync;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [AW-1:0] wr_data;
  logic [NC-1:0] ce;
  logic          locked;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_acc[NC];
  int   m_inc[NC];
  int   m_cnt;
  bit   m_locked;

  clk_enable_gen #(
    .NUM_CHANNELS(NC),
    .ACC_WIDTH(AW),
    .RESET_INC(RST_INC),
    .LOCK_CYCLES(LC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sync(sync),
    .wr_en(wr_en),
    .wr_sel(wr_sel),
    .wr_data(wr_data),
    .ce(ce),
    .locked(locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle, predicts the result of the coming edge and scores it after the edge.
  task automatic applyStimulus(input bit do_reset, input bit do_sync, input bit do_wr,
                               input int sel, input int data);
    exp_t      e;
    bit [NC-1:0] nce;
    int        s;
    reset   = do_reset;
    sync    = do_sync;
    wr_en   = do_wr;
    wr_sel  = 2'(sel);
    wr_data = 8'(data);
    nce = '0;
    if (do_reset) begin
      m_locked = 0;
      m_cnt    = 0;
      for (int n = 0; n < NC; n++) begin
        m_acc[n] = 0;
        m_inc[n] = int'(RST_INC[n*AW +: AW]);
      end
    end else begin
      if (m_locked) begin
        for (int n = 0; n < NC; n++) begin
          s = m_acc[n] + m_inc[n];
          nce[n] = (s >= 256);
          m_acc[n] = s % 256;
        end
      end
      if (do_sync) begin
        for (int n = 0; n < NC; n++) m_acc[n] = 0;
        nce = '0;
      end
      if (do_wr && sel < NC) begin
        m_inc[sel] = data;
        m_acc[sel] = 0;
        nce[sel]   = 1'b0;
      end
      if (!m_locked) begin
        m_cnt++;
        if (m_cnt == LC) m_locked = 1;
      end
    end
    e.ce     = nce;
    e.locked = m_locked;
    for (int n = 0; n < NC; n++) e.acc[n*AW +: AW] = 8'(m_acc[n]);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("ce", 32'(ce), 32'(e.ce));
      checkOutput("locked", 32'(locked), 32'(e.locked));
      checkOutput("acc", 32'(dut.acc), 32'(e.acc));
    end
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    int lock_edges, first, cnt, last, k, both, odd, gap;
    int gaps[3];
    int resid[3];
    gaps  = '{3, 3, 2};
    resid = '{32, 64, 0};
    reset = 1'b1; sync = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;

    repeat (3) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_inc", 32'(dut.inc), 32'(RST_INC));

    lock_edges = 0;
    for (int i = 0; i < 20 && !locked; i++) begin
      idle();
      lock_edges++;
    end
    checkOutput("lock_latency", lock_edges, LC);

    applyStimulus(0, 0, 1, 0, 64);
    first = 0; cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      idle();
      if (ce[0]) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    checkOutput("ch0_first", first, 4);
    checkOutput("ch0_count", cnt, 25);

    applyStimulus(0, 0, 1, 1, 96);
    cnt = 0; last = 0; k = 0;
    for (int i = 1; i <= 24; i++) begin
      idle();
      if (ce[1]) begin
        cnt++;
        checkOutput("ch1_gap", i - last, gaps[k % 3]);
        checkOutput("ch1_resid", 32'(dut.acc[1]), resid[k % 3]);
        last = i;
        k++;
      end
    end
    checkOutput("ch1_count", cnt, 9);

    applyStimulus(0, 0, 1, 1, 128);
    repeat (5) idle();
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("sync_acc", 32'(dut.acc[1:0]), 0);
    both = 0; odd = 0;
    for (int i = 1; i <= 16; i++) begin
      idle();
      if (ce[0] && ce[1]) both++;
      if (ce[0] && !ce[1]) odd++;
    end
    checkOutput("sync_coincide", both, 4);
    checkOutput("sync_misalign", odd, 0);

    applyStimulus(0, 0, 1, 2, 64);
    for (int i = 0; i < 10 && (m_acc[2] + m_inc[2] < 256); i++) idle();
    applyStimulus(0, 0, 1, 2, 128);
    checkOutput("ch2_suppress", 32'(ce[2]), 0);
    gap = 0;
    for (int i = 1; i <= 10 && gap == 0; i++) begin
      idle();
      if (ce[2]) gap = i;
    end
    checkOutput("ch2_new_period", gap, 2);

    applyStimulus(0, 0, 1, 3, 255);
    checkOutput("bad_sel_inc", 32'(dut.inc), 32'({8'd128, 8'd128, 8'd64}));

    repeat (3) idle();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_inc_again", 32'(dut.inc), 32'(RST_INC));
    gap = 0;
    for (int i = 1; i <= 40 && gap == 0; i++) begin
      idle();
      if (ce != '0) gap = i;
    end
    checkOutput("relock_first_pulse", gap, LC + 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
